// File: rtl/tx_uart_fifo_if.sv
// Byte-push handshake between a producer and the buffered UART transmitter.
// A push happens on a clock edge where i_valid && o_ready.
interface tx_uart_fifo_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/tx_uart_fifo.sv
// Buffered UART transmitter: a small FIFO feeding a start/data/[parity]/stop serialiser.
// Define UART_PARITY_EN to compile in the parity bit; the default build has no parity.
module tx_uart_fifo #(
  parameter int NB_DATA    = 8,
  parameter int OVERSAMPLE = 16,
  parameter int N_STOP     = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_s_tick,
  tx_uart_fifo_if.slave                    bus,
  output logic                             o_tx,
  output logic                             o_tx_done_tick,
  output logic                             o_busy,
  output logic [$clog2(FIFO_DEPTH):0]      o_fifo_count
);

  localparam int NB_ADDR = $clog2(FIFO_DEPTH);
  localparam int NB_TICK = $clog2(N_STOP * OVERSAMPLE);
  localparam int NB_IDX  = $clog2(NB_DATA);

  localparam logic [NB_TICK-1:0] TICK_BIT_LAST  = NB_TICK'(OVERSAMPLE - 1);
  localparam logic [NB_TICK-1:0] TICK_STOP_LAST = NB_TICK'(N_STOP * OVERSAMPLE - 1);
  localparam logic [NB_IDX-1:0]  IDX_LAST       = NB_IDX'(NB_DATA - 1);
  localparam logic [NB_ADDR:0]   COUNT_FULL     = (NB_ADDR + 1)'(FIFO_DEPTH);

  if (NB_DATA < 5 || NB_DATA > 9 || (N_STOP != 1 && N_STOP != 2) ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("tx_uart_fifo: illegal parameter combination");
  end

  // state  | meaning
  // IDLE   | line high, waiting for a queued byte
  // START  | start bit (low)
  // DATA   | data bits, LSB first
  // PARITY | parity bit (only with UART_PARITY_EN)
  // STOP   | stop bit(s), done pulse on the last tick
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  logic [NB_DATA-1:0] mem_q [FIFO_DEPTH];
  logic [NB_ADDR-1:0] wr_ptr_q, rd_ptr_q;
  logic [NB_ADDR:0]   count_q;
  logic               push, pop;

  state_t             state_q, state_d;
  logic [NB_TICK-1:0] tick_q, tick_d;
  logic [NB_IDX-1:0]  idx_q, idx_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
`ifdef UART_PARITY_EN
  logic               parity_q, parity_d;
`endif

  assign bus.o_ready = (count_q != COUNT_FULL);
  assign push        = bus.i_valid && bus.o_ready;
  assign pop         = (state_q == ST_IDLE) && (count_q != '0);

  always_ff @(posedge i_clock) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // tx_d carries the level of the state being entered so the line stays registered.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d  = ST_START;
          tx_d     = 1'b0;
          tick_d   = '0;
          shreg_d  = mem_q[rd_ptr_q];
`ifdef UART_PARITY_EN
          parity_d = (^mem_q[rd_ptr_q]) ^ (PARITY_ODD != 0);
`endif
        end
      end
      ST_START: begin
        if (i_s_tick) begin
          if (tick_q == TICK_BIT_LAST) begin
            state_d = ST_DATA;
            tick_d  = '0;
            idx_d   = '0;
            tx_d    = shreg_q[0];
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_s_tick) begin
          if (tick_q == TICK_BIT_LAST) begin
            tick_d = '0;
            if (idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
              state_d = ST_PARITY;
              tx_d    = parity_q;
`else
              state_d = ST_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              shreg_d = shreg_q >> 1;
              idx_d   = idx_q + 1'b1;
              tx_d    = shreg_q[1];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (i_s_tick) begin
          if (tick_q == TICK_BIT_LAST) begin
            state_d = ST_STOP;
            tick_d  = '0;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_s_tick) begin
          if (tick_q == TICK_STOP_LAST) begin
            state_d = ST_IDLE;
            tick_d  = '0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_tx           = tx_q;
  assign o_tx_done_tick = done_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_fifo_count   = count_q;

endmodule

// File: doc/tx_uart_fifo.md
# tx_uart_fifo

Parametrised, buffered UART transmitter, the successor to the single-byte `tx_uart`. It accepts bytes through a valid/ready handshake into an internal FIFO and serialises them back-to-back onto `o_tx`. Bit timing comes from the existing `baudrate_generator` tick. It sits between the ALU/result logic in `top` and the serial line, and also serves as the bench stimulus driver.

## Interface
- `NB_DATA`, default 8: data bits per frame (5–9).
- `OVERSAMPLE`, default 16: `i_s_tick` pulses per bit period.
- `N_STOP`, default 1: stop bits (1 or 2).
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.
- `FIFO_DEPTH`, default 4: FIFO entries, a power of two ≥ 2. `NB_ADDR = $clog2(FIFO_DEPTH)`.

Ports:
- `i_clock`  in  1  system clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_s_tick`  in  1  one-cycle baud-oversample strobe from `baudrate_generator`.
- `i_data`  in  NB_DATA  byte to send.
- `i_valid`  in  1  `i_data` is valid.
- `o_ready`  out  1  FIFO not full. Push occurs when `i_valid && o_ready`.
- `o_tx`  out  1  serial line, registered; idles high.
- `o_tx_done_tick`  out  1  one-cycle pulse at the end of each frame.
- `o_busy`  out  1  FSM not in IDLE.
- `o_fifo_count`  out  NB_ADDR+1  current number of queued entries.

## Operation
- **FIFO:** circular buffer with registered read/write pointers and a count.
  - Push writes at `wr_ptr`.
  - Pop happens when the FSM leaves IDLE: the head is loaded into the shift register.
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full is ignored (`o_ready` = 0).
  - Pointers wrap modulo FIFO_DEPTH.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `o_tx` = 1. If count ≠ 0, pop and go to START with `o_tx` = 0, tick counter cleared.
  - START: after OVERSAMPLE ticks, go to DATA with `o_tx` = shreg[0] and the bit index cleared.
  - DATA: send LSB first. Every OVERSAMPLE ticks, shift right and increment the index. After bit NB_DATA-1, go to PARITY if compiled in, otherwise STOP.
  - PARITY: `o_tx` = `^data ^ PARITY_ODD` for OVERSAMPLE ticks, then go to STOP.
  - STOP: `o_tx` = 1 for N_STOP×OVERSAMPLE ticks. On the final tick, pulse `o_tx_done_tick` and return to IDLE.
- **Counters:** the tick counter is wide enough for N_STOP×OVERSAMPLE−1. The bit index is `$clog2(NB_DATA)` bits wide.
- **Parity source:** parity is computed from the popped byte, captured at pop time.

## Timing
- **Reset values:** `o_tx` = 1, `o_tx_done_tick` = 0, `o_busy` = 0, `o_ready` = 1, `o_fifo_count` = 0. FIFO pointers and FSM are cleared.
- **Push to count:** a push is visible in `o_fifo_count` on the next cycle.
- **Idle to start bit:** from IDLE with a non-empty FIFO, `o_tx` falls on the next clock edge. The start bit lasts OVERSAMPLE ticks counted from the first tick after entry.
- **Back-to-back frames:** if the FIFO is non-empty when `o_tx_done_tick` fires, the FSM spends one cycle in IDLE and then starts the next frame. There is no extra idle bit.
- **Reset mid-frame:** `o_tx` goes to 1 asynchronously, queued data is discarded, and no done pulse is issued.
- **Tick timing:** `i_s_tick` is sampled only on clock edges. A tick in the same cycle as the IDLE→START transition is not counted.

## Configuration
- **`UART_PARITY_EN` defined:** the PARITY state is present and frames are 1+NB_DATA+1+N_STOP bits.
- **`UART_PARITY_EN` undefined:** the PARITY state and its logic are removed, DATA goes directly to STOP, and frames are 1+NB_DATA+N_STOP bits.

## Test plan
All scenarios use OVERSAMPLE=16, 50 MHz clock and the `baudrate_generator` tick.

- **Single byte, parity on:** push 0x55 with parity enabled, PARITY_ODD=0 → `o_tx` sends 0 | 1,0,1,0,1,0,1,0 | parity 0 | 1. Each bit lasts 16 ticks. Exactly one `o_tx_done_tick`.
- **Back-to-back:** push 85, 1, 32 on three consecutive cycles → three frames with no idle bit between them. `o_fifo_count` peaks at 2. Three done pulses.
- **Full FIFO:** hold `i_valid` high with six distinct bytes, FIFO_DEPTH=4 → 5 accepted (1 in flight plus 4 queued), `o_ready` = 0. The sixth byte is accepted in the cycle after the first done pulse. Bytes emerge in order.
- **Odd parity:** PARITY_ODD=1, byte 0x01 → parity bit 0. With PARITY_ODD=0 the same byte gives parity bit 1. With `UART_PARITY_EN` undefined, stop follows bit 7 directly.
- **Two stop bits:** N_STOP=2, push 0x20 → `o_tx` high for 32 ticks after the data. The done pulse fires on the 32nd stop tick.
- **Reset mid-frame:** assert `i_reset` during data bit 3 of 0x55 with 2 bytes queued → `o_tx` = 1 and `o_fifo_count` = 0 immediately, no done pulse. After release, `o_tx` stays high until a new push.
